// File: rtl/sata_defines.sv
// Shared definitions for the faux HD transport layer: FIS type codes,
// per-FIS fixed dword lengths, the transmit state encoding and the struct
// holding the device-to-host fields captured when a send strobe is accepted.
package sata_defines;

    localparam int DEF_MAX_PAYLOAD_DW = 2048;
    localparam int DEF_PAYLOAD_W      = 24;

    localparam logic [7:0] FIS_CODE_REG_D2H  = 8'h34;
    localparam logic [7:0] FIS_CODE_DMA_ACT  = 8'h39;
    localparam logic [7:0] FIS_CODE_DATA     = 8'h46;
    localparam logic [7:0] FIS_CODE_PIO      = 8'h5F;
    localparam logic [7:0] FIS_CODE_DEV_BITS = 8'hA1;

    typedef enum logic [2:0] {
        FT_REG,
        FT_DMA_ACT,
        FT_DATA,
        FT_PIO,
        FT_DEV_BITS
    } fis_type_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_HDR,
        ST_FIXED,
        ST_PAYLOAD,
        ST_WAIT_FIN
    } tx_state_e;

    typedef struct packed {
        logic        interrupt;
        logic        notification;
        logic [7:0]  status;
        logic [7:0]  error;
        logic [7:0]  device;
        logic [3:0]  port_mult;
        logic [47:0] lba;
        logic [15:0] sector_count;
        logic [15:0] pio_count;
        logic        pio_dir;
        logic [7:0]  e_status;
    } d2h_fields_t;

    // Dwords sent from the builder (header plus fixed body). A data FIS
    // only has its header here; the payload length comes from the source.
    function automatic logic [2:0] fis_fixed_len(input fis_type_e t);
        case (t)
            FT_REG:      return 3'd5;
            FT_PIO:      return 3'd5;
            FT_DEV_BITS: return 3'd2;
            default:     return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/faux_hd_fis_builder.sv
// Combinational FIS dword generator.
// Ports:
//   fis_type_i - which FIS is being sent
//   dw_idx_i   - dword index within the fixed part of the FIS (0 = header)
//   fields_i   - field values latched at strobe acceptance
//   dword_o    - the 32-bit dword for that index (byte0 = bits[7:0])
module faux_hd_fis_builder
    import sata_defines::*;
(
    input  fis_type_e   fis_type_i,
    input  logic [2:0]  dw_idx_i,
    input  d2h_fields_t fields_i,
    output logic [31:0] dword_o
);

    always_comb begin
        dword_o = '0;
        case (fis_type_i)
            FT_REG: begin
                case (dw_idx_i)
                    3'd0: dword_o = {fields_i.error, fields_i.status, 1'b0, fields_i.interrupt,
                                     2'b00, fields_i.port_mult, FIS_CODE_REG_D2H};
                    3'd1: dword_o = {fields_i.device, fields_i.lba[23:0]};
                    3'd2: dword_o = {8'h00, fields_i.lba[47:24]};
                    3'd3: dword_o = {16'h0000, fields_i.sector_count};
                    default: dword_o = '0;
                endcase
            end
            FT_PIO: begin
                case (dw_idx_i)
                    3'd0: dword_o = {fields_i.error, fields_i.status, 1'b0, fields_i.interrupt,
                                     fields_i.pio_dir, 1'b0, fields_i.port_mult, FIS_CODE_PIO};
                    3'd1: dword_o = {fields_i.device, fields_i.lba[23:0]};
                    3'd2: dword_o = {8'h00, fields_i.lba[47:24]};
                    3'd3: dword_o = {fields_i.e_status, 8'h00, fields_i.sector_count};
                    3'd4: dword_o = {16'h0000, fields_i.pio_count};
                    default: dword_o = '0;
                endcase
            end
            FT_DEV_BITS: begin
                // Status bit 7 position is reserved in the set-device-bits FIS.
                if (dw_idx_i == 3'd0)
                    dword_o = {fields_i.error, 1'b0, fields_i.status[6:0], fields_i.notification,
                               fields_i.interrupt, 2'b00, fields_i.port_mult, FIS_CODE_DEV_BITS};
            end
            FT_DMA_ACT: dword_o = {20'h0, fields_i.port_mult, FIS_CODE_DMA_ACT};
            FT_DATA:    dword_o = {20'h0, fields_i.port_mult, FIS_CODE_DATA};
            default:    dword_o = '0;
        endcase
    end

endmodule

// File: rtl/faux_hd_transport_tx.sv
// Transmit half of the faux HD transport layer. Accepts one send strobe at a
// time from the command layer, serialises the matching device-to-host FIS
// into dwords for the link layer, and for data FISes streams the payload
// straight from the command layer's incoming-data channel.
// Ports:
//   clk, rst_n                       - clock, synchronous active-low reset
//   transport_layer_ready            - idle and link ready
//   send_*_stb                       - FIS requests (reg > dma_act > data > pio > dev_bits)
//   remote_abort, xmit_error         - one-cycle link error pulses
//   strobe_collision                 - pulse when several strobes arrive together
//   d2h_*, pio_*                     - FIS field values, captured on acceptance
//   cl_if_*                          - payload source (claim, pop, data, ready, size)
//   ll_*                             - link layer write interface and status
module faux_hd_transport_tx
    import sata_defines::*;
#(
    parameter int MAX_PAYLOAD_DW = DEF_MAX_PAYLOAD_DW,
    parameter int PAYLOAD_W      = DEF_PAYLOAD_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 transport_layer_ready,
    input  logic                 send_reg_stb,
    input  logic                 send_dma_act_stb,
    input  logic                 send_data_stb,
    input  logic                 send_pio_stb,
    input  logic                 send_dev_bits_stb,
    output logic                 remote_abort,
    output logic                 xmit_error,
    output logic                 strobe_collision,
    input  logic                 d2h_interrupt,
    input  logic                 d2h_notification,
    input  logic [7:0]           d2h_status,
    input  logic [7:0]           d2h_error,
    input  logic [7:0]           d2h_device,
    input  logic [3:0]           d2h_port_mult,
    input  logic [47:0]          d2h_lba,
    input  logic [15:0]          d2h_sector_count,
    input  logic [15:0]          pio_transfer_count,
    input  logic                 pio_direction,
    input  logic [7:0]           pio_e_status,
    output logic                 cl_if_activate,
    output logic                 cl_if_strobe,
    input  logic [31:0]          cl_if_data,
    input  logic                 cl_if_ready,
    input  logic [PAYLOAD_W-1:0] cl_if_size,
    input  logic                 ll_ready,
    output logic                 ll_write_start,
    output logic                 ll_write_strobe,
    output logic [31:0]          ll_write_data,
    output logic [PAYLOAD_W-1:0] ll_write_size,
    input  logic                 ll_write_hold,
    input  logic                 ll_write_finished,
    input  logic                 ll_xmit_error,
    input  logic                 ll_remote_abort
);

    localparam int CNT_W = $clog2(MAX_PAYLOAD_DW);

    tx_state_e            state_q;
    fis_type_e            fis_q;
    d2h_fields_t          fields_q;
    logic [2:0]           idx_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 pay_empty_q;
    logic                 rdy_q;
    logic                 start_q;
    logic                 activate_q;
    logic                 coll_q;
    logic                 rabort_q;
    logic                 xerr_q;
    logic [PAYLOAD_W-1:0] size_q;

    d2h_fields_t          live_f;
    fis_type_e            stb_type;
    logic [4:0]           stb_vec;
    logic                 any_stb;
    logic                 multi_stb;
    logic [PAYLOAD_W-1:0] n_cap;
    logic [2:0]           fix_len;
    logic [31:0]          fis_dw;
    logic                 link_err;

    always_comb begin
        live_f              = '0;
        live_f.interrupt    = d2h_interrupt;
        live_f.notification = d2h_notification;
        live_f.status       = d2h_status;
        live_f.error        = d2h_error;
        live_f.device       = d2h_device;
        live_f.port_mult    = d2h_port_mult;
        live_f.lba          = d2h_lba;
        live_f.sector_count = d2h_sector_count;
        live_f.pio_count    = pio_transfer_count;
        live_f.pio_dir      = pio_direction;
        live_f.e_status     = pio_e_status;
    end

    assign stb_vec   = {send_dev_bits_stb, send_pio_stb, send_data_stb, send_dma_act_stb, send_reg_stb};
    assign any_stb   = |stb_vec;
    // More than one bit set <=> clearing the lowest set bit leaves something.
    assign multi_stb = (stb_vec & (stb_vec - 5'd1)) != 5'd0;

    always_comb begin
        stb_type = FT_DEV_BITS;
        if (send_reg_stb)          stb_type = FT_REG;
        else if (send_dma_act_stb) stb_type = FT_DMA_ACT;
        else if (send_data_stb)    stb_type = FT_DATA;
        else if (send_pio_stb)     stb_type = FT_PIO;
    end

    assign n_cap    = (cl_if_size > PAYLOAD_W'(MAX_PAYLOAD_DW)) ? PAYLOAD_W'(MAX_PAYLOAD_DW) : cl_if_size;
    assign fix_len  = fis_fixed_len(fis_q);
    assign link_err = ll_xmit_error | ll_remote_abort;

    faux_hd_fis_builder u_builder (
        .fis_type_i (fis_q),
        .dw_idx_i   (idx_q),
        .fields_i   (fields_q),
        .dword_o    (fis_dw)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            fis_q       <= FT_REG;
            fields_q    <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            pay_empty_q <= 1'b0;
            rdy_q       <= 1'b0;
            start_q     <= 1'b0;
            activate_q  <= 1'b0;
            coll_q      <= 1'b0;
            rabort_q    <= 1'b0;
            xerr_q      <= 1'b0;
            size_q      <= '0;
        end else begin
            start_q  <= 1'b0;
            coll_q   <= 1'b0;
            rabort_q <= 1'b0;
            xerr_q   <= 1'b0;
            rdy_q    <= 1'b0;
            if (state_q != ST_IDLE && link_err) begin
                rabort_q   <= ll_remote_abort;
                xerr_q     <= ll_xmit_error;
                activate_q <= 1'b0;
                state_q    <= ST_IDLE;
                rdy_q      <= ll_ready;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        rdy_q <= ll_ready;
                        if (any_stb) begin
                            fis_q    <= stb_type;
                            fields_q <= live_f;
                            coll_q   <= multi_stb;
                            idx_q    <= '0;
                            state_q  <= ST_ARM;
                            rdy_q    <= 1'b0;
                        end
                    end
                    ST_ARM: begin
                        if (fis_q == FT_DATA) begin
                            if (cl_if_ready) begin
                                activate_q  <= 1'b1;
                                start_q     <= 1'b1;
                                size_q      <= n_cap + PAYLOAD_W'(1);
                                pay_empty_q <= (n_cap == '0);
                                // Counter holds dwords remaining minus one so the
                                // full cap still fits in CNT_W bits.
                                cnt_q       <= CNT_W'(n_cap - PAYLOAD_W'(1));
                                state_q     <= ST_HDR;
                            end
                        end else begin
                            start_q <= 1'b1;
                            size_q  <= PAYLOAD_W'(fix_len);
                            state_q <= ST_HDR;
                        end
                    end
                    ST_HDR: begin
                        if (!ll_write_hold) begin
                            if (fis_q == FT_DATA) begin
                                if (pay_empty_q) begin
                                    activate_q <= 1'b0;
                                    state_q    <= ST_WAIT_FIN;
                                end else begin
                                    state_q <= ST_PAYLOAD;
                                end
                            end else if (fix_len == 3'd1) begin
                                state_q <= ST_WAIT_FIN;
                            end else begin
                                idx_q   <= 3'd1;
                                state_q <= ST_FIXED;
                            end
                        end
                    end
                    ST_FIXED: begin
                        if (!ll_write_hold) begin
                            if (idx_q == fix_len - 3'd1) state_q <= ST_WAIT_FIN;
                            else                         idx_q   <= idx_q + 3'd1;
                        end
                    end
                    ST_PAYLOAD: begin
                        if (!ll_write_hold) begin
                            if (cnt_q == '0) begin
                                activate_q <= 1'b0;
                                state_q    <= ST_WAIT_FIN;
                            end else begin
                                cnt_q <= cnt_q - CNT_W'(1);
                            end
                        end
                    end
                    ST_WAIT_FIN: begin
                        if (ll_write_finished) begin
                            state_q <= ST_IDLE;
                            rdy_q   <= ll_ready;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    // Dword strobes follow the hold input in the same cycle so a stalled link
    // never sees a transfer; data comes from the registered state and is
    // therefore stable while held.
    assign ll_write_strobe = (state_q == ST_HDR || state_q == ST_FIXED || state_q == ST_PAYLOAD)
                             && !ll_write_hold;
    assign cl_if_strobe    = (state_q == ST_PAYLOAD) && !ll_write_hold;

    always_comb begin
        ll_write_data = '0;
        case (state_q)
            ST_HDR, ST_FIXED: ll_write_data = fis_dw;
            ST_PAYLOAD:       ll_write_data = cl_if_data;
            default:          ll_write_data = '0;
        endcase
    end

    assign transport_layer_ready = rdy_q;
    assign ll_write_start        = start_q;
    assign ll_write_size         = size_q;
    assign cl_if_activate        = activate_q;
    assign strobe_collision      = coll_q;
    assign remote_abort          = rabort_q;
    assign xmit_error            = xerr_q;

endmodule

// File: tb/tb_faux_hd_transport_tx.sv
module tb_faux_hd_transport_tx;

    localparam int K_REG = 0, K_DMA = 1, K_DATA = 2, K_PIO = 3, K_SDB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        transport_layer_ready;
    logic        send_reg_stb, send_dma_act_stb, send_data_stb, send_pio_stb, send_dev_bits_stb;
    logic        remote_abort, xmit_error, strobe_collision;
    logic        d2h_interrupt, d2h_notification;
    logic [7:0]  d2h_status, d2h_error, d2h_device;
    logic [3:0]  d2h_port_mult;
    logic [47:0] d2h_lba;
    logic [15:0] d2h_sector_count, pio_transfer_count;
    logic        pio_direction;
    logic [7:0]  pio_e_status;
    logic        cl_if_activate, cl_if_strobe;
    logic [31:0] cl_if_data;
    logic        cl_if_ready;
    logic [23:0] cl_if_size;
    logic        ll_ready, ll_write_start, ll_write_strobe;
    logic [31:0] ll_write_data;
    logic [23:0] ll_write_size;
    logic        ll_write_hold, ll_write_finished, ll_xmit_error, ll_remote_abort;

    faux_hd_transport_tx dut (
        .clk(clk), .rst_n(rst_n), .transport_layer_ready(transport_layer_ready),
        .send_reg_stb(send_reg_stb), .send_dma_act_stb(send_dma_act_stb),
        .send_data_stb(send_data_stb), .send_pio_stb(send_pio_stb),
        .send_dev_bits_stb(send_dev_bits_stb), .remote_abort(remote_abort),
        .xmit_error(xmit_error), .strobe_collision(strobe_collision),
        .d2h_interrupt(d2h_interrupt), .d2h_notification(d2h_notification),
        .d2h_status(d2h_status), .d2h_error(d2h_error), .d2h_device(d2h_device),
        .d2h_port_mult(d2h_port_mult), .d2h_lba(d2h_lba),
        .d2h_sector_count(d2h_sector_count), .pio_transfer_count(pio_transfer_count),
        .pio_direction(pio_direction), .pio_e_status(pio_e_status),
        .cl_if_activate(cl_if_activate), .cl_if_strobe(cl_if_strobe),
        .cl_if_data(cl_if_data), .cl_if_ready(cl_if_ready), .cl_if_size(cl_if_size),
        .ll_ready(ll_ready), .ll_write_start(ll_write_start),
        .ll_write_strobe(ll_write_strobe), .ll_write_data(ll_write_data),
        .ll_write_size(ll_write_size), .ll_write_hold(ll_write_hold),
        .ll_write_finished(ll_write_finished), .ll_xmit_error(ll_xmit_error),
        .ll_remote_abort(ll_remote_abort)
    );

    int tests = 0, fails = 0;

    // link/payload model state
    logic [31:0] rx[$];
    logic [31:0] exp_q[$];
    int n_start = 0, n_pop = 0, n_coll = 0, n_rab = 0, n_xer = 0, bad_pop = 0, bad_hold = 0;
    logic [23:0] last_size = '0;
    int exp_len = 0, pop_idx = 0, hold_mode = 0, cyc = 0;
    bit fin_done = 0, fin_now = 0, pop_pending = 0;
    logic [31:0] pay_base = '0;

    // fields as they were when the strobe was applied
    logic [7:0]  s_err, s_stat, s_dev, s_es;
    logic [3:0]  s_pm;
    logic [47:0] s_lba;
    logic [15:0] s_sc, s_pc;
    logic        s_i, s_n, s_dir;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pay_word(input int i);
        return pay_base ^ (32'(i) * 32'h9E3779B9);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (pop_pending) begin pop_idx++; pop_pending = 1'b0; end
        cl_if_data = pay_word(pop_idx);
        ll_write_finished = fin_now;
        fin_now = 1'b0;
        case (hold_mode)
            1:       ll_write_hold = ((cyc / 3) % 2) == 1;
            2:       ll_write_hold = ($urandom_range(0, 3) == 0);
            default: ll_write_hold = 1'b0;
        endcase
        cyc++;
        @(negedge clk);
        if (ll_write_start) begin n_start++; last_size = ll_write_size; end
        if (ll_write_strobe) rx.push_back(ll_write_data);
        if (ll_write_strobe && ll_write_hold) bad_hold++;
        if (cl_if_strobe) begin
            n_pop++;
            pop_pending = 1'b1;
            if (!ll_write_strobe || ll_write_hold || ll_write_data !== cl_if_data) bad_pop++;
        end
        if (strobe_collision) n_coll++;
        if (remote_abort) n_rab++;
        if (xmit_error) n_xer++;
        if (!fin_done && exp_len > 0 && rx.size() == exp_len) begin fin_now = 1'b1; fin_done = 1'b1; end
    endtask

    task automatic rand_fields();
        d2h_interrupt = 1'($urandom); d2h_notification = 1'($urandom);
        d2h_status = 8'($urandom); d2h_error = 8'($urandom); d2h_device = 8'($urandom);
        d2h_port_mult = 4'($urandom); d2h_lba = {16'($urandom), 32'($urandom)};
        d2h_sector_count = 16'($urandom); pio_transfer_count = 16'($urandom);
        pio_direction = 1'($urandom); pio_e_status = 8'($urandom);
    endtask

    task automatic set_stb(input int k, input logic v);
        case (k)
            K_REG:   send_reg_stb = v;
            K_DMA:   send_dma_act_stb = v;
            K_DATA:  send_data_stb = v;
            K_PIO:   send_pio_stb = v;
            default: send_dev_bits_stb = v;
        endcase
    endtask

    task automatic clear_stbs();
        send_reg_stb = 0; send_dma_act_stb = 0; send_data_stb = 0; send_pio_stb = 0; send_dev_bits_stb = 0;
    endtask

    // Expected frame straight from the FIS layout tables.
    task automatic build_exp(input int kind, input int n);
        exp_q.delete();
        case (kind)
            K_REG: begin
                exp_q.push_back({s_err, s_stat, 1'b0, s_i, 2'b00, s_pm, 8'h34});
                exp_q.push_back({s_dev, s_lba[23:0]});
                exp_q.push_back({8'h00, s_lba[47:24]});
                exp_q.push_back({16'h0, s_sc});
                exp_q.push_back(32'h0);
            end
            K_DMA: exp_q.push_back({20'h0, s_pm, 8'h39});
            K_PIO: begin
                exp_q.push_back({s_err, s_stat, 1'b0, s_i, s_dir, 1'b0, s_pm, 8'h5F});
                exp_q.push_back({s_dev, s_lba[23:0]});
                exp_q.push_back({8'h00, s_lba[47:24]});
                exp_q.push_back({s_es, 8'h00, s_sc});
                exp_q.push_back({16'h0, s_pc});
            end
            K_SDB: begin
                exp_q.push_back({s_err, 1'b0, s_stat[6:0], s_n, s_i, 2'b00, s_pm, 8'hA1});
                exp_q.push_back(32'h0);
            end
            default: begin
                exp_q.push_back({20'h0, s_pm, 8'h46});
                for (int i = 0; i < n; i++) exp_q.push_back(pay_word(i));
            end
        endcase
    endtask

    // One complete frame. low_kind >= 0 adds a lower-priority strobe in the
    // same cycle; intrude pulses another strobe mid-frame; rdly holds
    // cl_if_ready low for that many cycles.
    task automatic run_frame(input int kind, input logic [23:0] csize, input int hmode,
                             input int low_kind, input bit intrude, input int rdly);
        int n, t, s_start, s_pop, s_coll;
        s_err = d2h_error; s_stat = d2h_status; s_dev = d2h_device; s_es = pio_e_status;
        s_pm = d2h_port_mult; s_lba = d2h_lba; s_sc = d2h_sector_count; s_pc = pio_transfer_count;
        s_i = d2h_interrupt; s_n = d2h_notification; s_dir = pio_direction;
        pay_base = $urandom;
        n = (kind != K_DATA) ? 0 : ((csize > 24'd2048) ? 2048 : int'(csize));
        build_exp(kind, n);
        cl_if_size = csize; cl_if_ready = (rdly == 0);
        pop_idx = 0; pop_pending = 0; cl_if_data = pay_word(0);
        rx.delete(); exp_len = exp_q.size(); fin_done = 0; hold_mode = hmode;
        s_start = n_start; s_pop = n_pop; s_coll = n_coll;
        set_stb(kind, 1'b1);
        if (low_kind >= 0) set_stb(low_kind, 1'b1);
        tick();
        check("rdy_after_stb", transport_layer_ready, 0);
        clear_stbs();
        rand_fields();
        t = 0;
        while (!(fin_done && ll_write_finished) && t < 20000) begin
            if (kind == K_DATA && rdly > 0 && t == rdly) begin
                check("no_start_before_ready", n_start - s_start, 0);
                cl_if_ready = 1'b1;
            end
            if (intrude && t == 4) send_dma_act_stb = 1'b1;
            tick();
            send_dma_act_stb = 1'b0;
            t++;
        end
        check("frame_done_in_time", t < 20000, 1);
        tick();
        check("rdy_after_fin", transport_layer_ready, 1);
        hold_mode = 0; exp_len = 0;
        check("start_pulses", n_start - s_start, 1);
        check("write_size", last_size, exp_q.size());
        check("dword_count", rx.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx.size(); i++)
            check($sformatf("dw%0d", i), rx[i], exp_q[i]);
        check("payload_pops", n_pop - s_pop, n);
        check("pop_not_paired", bad_pop, 0);
        check("strobe_in_hold", bad_hold, 0);
        check("collision_pulses", n_coll - s_coll, (low_kind >= 0) ? 1 : 0);
        for (int i = 0; i < 3; i++) tick();
        check("no_extra_frame", n_start - s_start, 1);
    endtask

    initial begin
        int s_pop, t, k, lo;
        rst_n = 0; clear_stbs(); rand_fields();
        cl_if_data = '0; cl_if_ready = 0; cl_if_size = '0;
        ll_ready = 1; ll_write_hold = 0; ll_write_finished = 0; ll_xmit_error = 0; ll_remote_abort = 0;
        repeat (3) tick();
        check("rst_ready", transport_layer_ready, 0);
        check("rst_start", ll_write_start, 0);
        check("rst_strobe", ll_write_strobe, 0);
        check("rst_data", ll_write_data, 0);
        check("rst_size", ll_write_size, 0);
        check("rst_act", cl_if_activate, 0);
        check("rst_pop", cl_if_strobe, 0);
        check("rst_errs", {remote_abort, xmit_error, strobe_collision}, 0);
        rst_n = 1;
        tick();
        check("ready_out_of_reset", transport_layer_ready, 1);

        // directed REG
        rand_fields();
        d2h_status = 8'h50; d2h_error = 8'h01; d2h_lba = 48'h1; d2h_sector_count = 16'h1;
        d2h_interrupt = 0; d2h_port_mult = 0; d2h_device = 0;
        run_frame(K_REG, 24'h0, 0, -1, 0, 0);
        check("reg_dw0_literal", rx[0], 32'h01500034);
        check("reg_dw3_literal", rx[3], 32'h00000001);

        // DMA activate with pm=0, with a strobe intruding mid-frame
        rand_fields(); d2h_port_mult = 0;
        run_frame(K_DMA, 24'h0, 0, -1, 1, 0);
        check("dma_literal", rx[0], 32'h00000039);

        // data, hold toggling every 3 cycles
        rand_fields();
        run_frame(K_DATA, 24'h100, 1, -1, 0, 0);
        // cap
        rand_fields();
        run_frame(K_DATA, 24'h1000, 0, -1, 0, 0);
        // empty payload
        rand_fields();
        run_frame(K_DATA, 24'h0, 2, -1, 0, 0);
        // collision REG + DATA
        rand_fields();
        run_frame(K_REG, 24'h20, 0, K_DATA, 0, 0);

        // remote abort part way through the payload
        rand_fields();
        cl_if_size = 24'd64; cl_if_ready = 1; pay_base = $urandom;
        pop_idx = 0; pop_pending = 0; cl_if_data = pay_word(0);
        exp_len = 0; rx.delete(); hold_mode = 0; s_pop = n_pop;
        send_data_stb = 1; tick(); send_data_stb = 0;
        t = 0;
        while (n_pop - s_pop < 10 && t < 500) begin tick(); t++; end
        check("abort_reached_dw10", n_pop - s_pop, 10);
        ll_remote_abort = 1; tick(); ll_remote_abort = 0;
        check("abort_pulse", remote_abort, 1);
        check("abort_no_xerr", xmit_error, 0);
        check("abort_act_drop", cl_if_activate, 0);
        check("abort_strobes", {ll_write_strobe, cl_if_strobe}, 0);
        tick();
        check("abort_one_cycle", remote_abort, 0);
        check("abort_back_idle", transport_layer_ready, 1);
        rand_fields();
        run_frame(K_REG, 24'h0, 0, -1, 0, 0);

        // both link errors at once
        rand_fields(); exp_len = 0; rx.delete();
        send_pio_stb = 1; tick(); send_pio_stb = 0;
        tick(); tick();
        ll_remote_abort = 1; ll_xmit_error = 1; tick(); ll_remote_abort = 0; ll_xmit_error = 0;
        check("both_err_pulse", {remote_abort, xmit_error}, 2'b11);
        tick();
        check("both_err_clear", {remote_abort, xmit_error}, 2'b00);

        // reset mid-frame
        rand_fields(); cl_if_size = 24'd50; cl_if_ready = 1; exp_len = 0;
        send_data_stb = 1; tick(); send_data_stb = 0;
        repeat (5) tick();
        rst_n = 0; tick();
        check("midrst_outputs", {cl_if_activate, ll_write_strobe, cl_if_strobe, transport_layer_ready}, 0);
        rst_n = 1; tick();
        check("midrst_ready", transport_layer_ready, 1);

        // randomized frames
        for (int it = 0; it < 16; it++) begin
            rand_fields();
            k = $urandom_range(0, 4);
            lo = (k < 4 && $urandom_range(0, 3) == 0) ? $urandom_range(k + 1, 4) : -1;
            run_frame(k, 24'($urandom_range(0, 300)), 2, lo, 0, (k == K_DATA) ? $urandom_range(0, 3) : 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/faux_hd_transport_tx.md
Name: faux_hd_transport_tx

Overview:
Transmit half of the simulated hard-drive transport layer. It sits directly downstream of the faux HD command layer. On a send strobe it serialises the matching device-to-host FIS into 32-bit dwords and hands them to the link layer. For data FISes it pulls the payload from the command layer's incoming-data interface (cl_if_*).

Parameters:
- MAX_PAYLOAD_DW, 2048: cap on data-FIS payload in dwords (8 KiB).
- PAYLOAD_W, 24: width of size fields.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- transport_layer_ready  out  1  idle and link ready; may accept a strobe
- send_reg_stb, send_dma_act_stb, send_data_stb, send_pio_stb, send_dev_bits_stb  in  1 each  FIS requests
- remote_abort, xmit_error  out  1 each  one-cycle error pulses to the command layer
- strobe_collision  out  1  pulse: more than one send strobe in the same cycle
- d2h_interrupt, d2h_notification  in  1  flag bits
- d2h_status, d2h_error, d2h_device  in  8  register fields
- d2h_port_mult  in  4  port multiplier
- d2h_lba  in  48  LBA
- d2h_sector_count  in  16  sector count
- pio_transfer_count  in  16  PIO count
- pio_direction  in  1  PIO direction
- pio_e_status  in  8  PIO ending status
- cl_if_activate  out  1  payload channel claim
- cl_if_strobe  out  1  payload dword pop
- cl_if_data  in  32  payload (combinational from source)
- cl_if_ready  in  1  payload available
- cl_if_size  in  24  payload dwords available
- ll_ready  in  1  link idle
- ll_write_start  out  1  frame start pulse
- ll_write_strobe  out  1  dword valid
- ll_write_data  out  32  dword
- ll_write_size  out  24  total frame dwords including header
- ll_write_hold  in  1  link stall
- ll_write_finished  in  1  frame done
- ll_xmit_error, ll_remote_abort  in  1  link errors

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE. All outputs are 0, including transport_layer_ready.
- transport_layer_ready is registered: (next_state==IDLE) && ll_ready. It must read 0 in the cycle after any accepted strobe.
- Strobe priority: reg > dma_act > data > pio > dev_bits. Lower-priority strobes in the same cycle are dropped, and strobe_collision pulses.
- Strobes arriving outside IDLE are ignored.
- Field values are captured at strobe acceptance and held for the whole frame.
- FIS layouts (byte0 = bits[7:0]):
  - REG 0x34, 5 dw: {err, status, 0, I, 0, pm, 0x34}, {dev, lba[23:0]}, {8'h0, lba[47:24]}, {16'h0, sc}, 0.
  - DMA_ACT 0x39, 1 dw: {16'h0, 4'h0, pm, 0x39}.
  - PIO 0x5F, 5 dw: {err, status, 0, I, D=pio_direction, 0, pm, 0x5F}, {dev, lba[23:0]}, {8'h0, lba[47:24]}, {e_status, 8'h0, sc}, {16'h0, pio_transfer_count}.
  - DEV_BITS 0xA1, 2 dw: {err, 0, status, N, I, 0, pm, 0xA1}, 0.
  - DATA 0x46: header {16'h0, 4'h0, pm, 0x46} followed by N payload dwords. N = min(cl_if_size, MAX_PAYLOAD_DW), latched in ARM; N=0 sends the header only.
- States:
  - IDLE -> ARM on an accepted strobe.
  - ARM:
    - DATA frames: wait cl_if_ready, assert cl_if_activate, latch N.
    - Other frames: go straight on.
    - In both cases pulse ll_write_start with ll_write_size = frame length, then go to HDR.
  - HDR: drive the header dword with ll_write_strobe while ll_write_hold=0. Then go to FIXED, PAYLOAD or WAIT_FIN.
  - FIXED: remaining fixed dwords, one per non-held cycle.
  - PAYLOAD: ll_write_strobe and cl_if_strobe are asserted together on each non-held cycle, with ll_write_data = cl_if_data. An 11-bit down-counter reaches 0 -> drop cl_if_activate -> WAIT_FIN.
  - WAIT_FIN: ll_write_finished -> IDLE.
- ll_write_hold=1: no strobes and no counter change; data is held stable.
- ll_xmit_error or ll_remote_abort in any non-IDLE state:
  - Next cycle: pulse the matching error output, deassert cl_if_activate and all strobes, go to IDLE.
  - If both are asserted, both pulse.
- rst_n low mid-frame aborts immediately. No ll_write_finished is awaited.

Decomposition:
- Shared package (sata_defines): FIS type codes, FIS dword lengths, state encodings.
- One sub-module, faux_hd_fis_builder: combinational mux from (fis_type, dword index, latched fields) to a 32-bit dword.

Test Plan:
- Reset, then send_reg_stb with status=8'h50, err=8'h01, lba=48'h1, sc=1 -> one ll_write_start with size=5. Dwords 0x01500034, 0x00000001, 0, 0x00000001, 0. transport_layer_ready is 0 the next cycle and 1 after ll_write_finished.
- send_dma_act_stb with pm=0 -> size=1, single dword 0x00000039.
- send_data_stb with cl_if_size=24'h100 and ll_write_hold toggling every 3 cycles -> size=257, header 0x00000046, then exactly 256 cl_if_strobe pulses, all coincident with ll_write_strobe, none during hold.
- cl_if_size=24'h1000 -> N capped at 2048, size=2049.
- send_reg_stb and send_data_stb in the same cycle -> REG FIS sent, strobe_collision pulses once, no data frame.
- ll_remote_abort at payload dword 10 -> remote_abort pulses one cycle, cl_if_activate drops, state returns to IDLE, and a new send_reg_stb completes normally.
